// File: rtl/multiply_arbiter_pkg.sv
// Shared constants for the multiply arbiter: default operand width, requester count,
// and the tag width used to identify requesters in flight.
package multiply_arbiter_pkg;

    localparam int ARGW_DEF = 16;
    localparam int N_DEF    = 4;

    // Tag width never collapses to zero bits, even for degenerate requester counts.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TAGW = tag_width(N_DEF);

endpackage

// File: rtl/multiply_arbiter_tag_fifo.sv
// Purpose: small in-order FIFO of requester tags for products still in the multiplier.
// Latency: head valid the cycle after push; push and pop both take effect at the next edge.
// Backpressure: push ignored while full (even with a same-cycle pop); pop ignored while empty.
module tag_fifo #(
    parameter int W     = 2,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign head    = mem_q[rd_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) begin
            mem_d[wr_q] = din;
            wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multiply_arbiter.sv
// Purpose: round-robin share of one pipelined multiplier among N requesters, results routed back by tag.
// Latency: zero cycles added on the issue path; products pass straight through to the head requester.
// Backpressure: issue stalls on full tag FIFO or mul_arg_rdy low; a stalled head requester blocks all later results.
module multiply_arbiter
    import multiply_arbiter_pkg::*;
#(
    parameter int ARGW  = ARGW_DEF,
    parameter int N     = N_DEF,
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N-1:0]          req_stb,
    input  logic [N*2*ARGW-1:0]   req_dat,
    output logic [N-1:0]          req_rdy,
    output logic [N-1:0]          rsp_stb,
    output logic [2*ARGW-1:0]     rsp_dat,
    input  logic [N-1:0]          rsp_rdy,
    output logic                  mul_arg_stb,
    output logic [2*ARGW-1:0]     mul_arg_dat,
    input  logic                  mul_arg_rdy,
    input  logic                  mul_res_stb,
    input  logic [2*ARGW-1:0]     mul_res_dat,
    output logic                  mul_res_rdy,
    output logic                  err
);

    localparam int TW = tag_width(N);
    localparam int PW = 2 * ARGW;

    logic [TW-1:0] ptr_q, ptr_d;
    logic          err_q, err_d;
    logic [TW-1:0] grant;
    logic [TW-1:0] hi_g, lo_g;
    logic          hi_found;
    logic [TW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          any_req;
    logic          issue;
    logic          pop;
    logic          head_rdy;

    assign any_req     = |req_stb;
    assign mul_arg_stb = any_req & ~fifo_full;
    assign issue       = mul_arg_stb & mul_arg_rdy;
    assign mul_res_rdy = head_rdy & ~fifo_empty;
    assign pop         = mul_res_stb & mul_res_rdy;
    assign rsp_dat     = mul_res_dat;
    assign err         = err_q;

    // Lowest requester at or above ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_g     = '0;
        lo_g     = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_stb[i]) begin
                lo_g = TW'(i);
                if (i >= int'(ptr_q)) begin
                    hi_g     = TW'(i);
                    hi_found = 1'b1;
                end
            end
        end
        grant = hi_found ? hi_g : lo_g;
    end

    always_comb begin
        mul_arg_dat = '0;
        req_rdy     = '0;
        rsp_stb     = '0;
        head_rdy    = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == TW'(i)) begin
                mul_arg_dat = req_dat[i*PW +: PW];
                req_rdy[i]  = issue;
            end
            if (head == TW'(i)) begin
                rsp_stb[i] = mul_res_stb & ~fifo_empty;
                head_rdy   = rsp_rdy[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (issue) begin
            ptr_d = (grant == TW'(N - 1)) ? '0 : grant + TW'(1);
        end
        // A product with no tag outstanding means the multiplier and arbiter disagree.
        err_d = err_q | (mul_res_stb & fifo_empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            err_q <= err_d;
        end
    end

    tag_fifo #(
        .W     (TW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue),
        .pop   (pop),
        .din   (grant),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );

endmodule

// File: tb/tb_multiply_arbiter.sv
// Bench for multiply_arbiter: directed scenarios plus randomized traffic against an
// in-order transaction model of requesters, tag FIFO and a behavioural multiplier.
module tb_multiply_arbiter;

    localparam int ARGW  = 16;
    localparam int N     = 4;
    localparam int DEPTH = 2;
    localparam int W     = 2 * ARGW;

    typedef struct {
        int          tag;
        logic [W-1:0] p;
    } ent_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N-1:0]       req_stb = '0;
    logic [N*W-1:0]     req_dat = '0;
    logic [N-1:0]       req_rdy;
    logic [N-1:0]       rsp_stb;
    logic [W-1:0]       rsp_dat;
    logic [N-1:0]       rsp_rdy = '0;
    logic               mul_arg_stb;
    logic [W-1:0]       mul_arg_dat;
    logic               mul_arg_rdy = 1'b0;
    logic               mul_res_stb = 1'b0;
    logic [W-1:0]       mul_res_dat = '0;
    logic               mul_res_rdy;
    logic               err;

    int n_cmp = 0;
    int n_bad = 0;

    // model state
    ent_t         ordq[$];
    int           m_ptr = 0;
    bit           m_err = 1'b0;
    logic [N-1:0] acc = '0;
    bit           res_acc = 1'b0;
    int           obs_q[$];

    // stimulus policy
    int           p_req = 0, p_arg = 100, p_res = 100, p_rsp = 100;
    logic [N-1:0] inj_stb = '0;
    logic [W-1:0] inj_dat [N];
    logic [N-1:0] rsp_hold = '0;
    bit           spur = 1'b0;

    multiply_arbiter #(.ARGW(ARGW), .N(N), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_stb     (req_stb),
        .req_dat     (req_dat),
        .req_rdy     (req_rdy),
        .rsp_stb     (rsp_stb),
        .rsp_dat     (rsp_dat),
        .rsp_rdy     (rsp_rdy),
        .mul_arg_stb (mul_arg_stb),
        .mul_arg_dat (mul_arg_dat),
        .mul_arg_rdy (mul_arg_rdy),
        .mul_res_stb (mul_res_stb),
        .mul_res_dat (mul_res_dat),
        .mul_res_rdy (mul_res_rdy),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [W-1:0] mul_ref(input logic [W-1:0] pair);
        logic signed [W-1:0] pa, pb;
        pa = W'($signed(pair[ARGW-1:0]));
        pb = W'($signed(pair[W-1:ARGW]));
        return pa * pb;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        req_stb     = '0;
        mul_res_stb = 1'b0;
        mul_arg_rdy = 1'b0;
        rsp_rdy     = '0;
        acc         = '0;
        res_acc     = 1'b0;
        spur        = 1'b0;
        inj_stb     = '0;
        rsp_hold    = '0;
        ordq.delete();
        m_ptr       = 0;
        m_err       = 1'b0;
        #1;
        check_eq("rst_err", err, 0);
        check_eq("rst_arg_stb", mul_arg_stb, 0);
        check_eq("rst_req_rdy", req_rdy, 0);
        check_eq("rst_rsp_stb", rsp_stb, 0);
        check_eq("rst_res_rdy", mul_res_rdy, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One clock: drive at the falling edge, check 1ns later, advance the model for the coming rising edge.
    task automatic cycle();
        int           g;
        int           h;
        int           idx;
        bit           any, full, empty, issue, exp_res_rdy;
        logic [N-1:0] exp_rdy, exp_rsp;
        logic [W-1:0] pair;
        ent_t         e;

        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (acc[i]) req_stb[i] = 1'b0;
            if (inj_stb[i]) begin
                req_stb[i]          = 1'b1;
                req_dat[i*W +: W]   = inj_dat[i];
            end else if (!req_stb[i] && ($urandom_range(99) < p_req)) begin
                req_stb[i]          = 1'b1;
                req_dat[i*W +: W]   = W'($urandom);
            end
            rsp_rdy[i] = ($urandom_range(99) < p_rsp) && !rsp_hold[i];
        end
        acc         = '0;
        inj_stb     = '0;
        mul_arg_rdy = ($urandom_range(99) < p_arg);
        if (res_acc) mul_res_stb = 1'b0;
        res_acc = 1'b0;
        if (spur) begin
            mul_res_stb = 1'b1;
            mul_res_dat = W'($urandom);
        end else if (ordq.size() == 0) begin
            mul_res_stb = 1'b0;
        end else if (!mul_res_stb && ($urandom_range(99) < p_res)) begin
            mul_res_stb = 1'b1;
            mul_res_dat = ordq[0].p;
        end

        #1;
        any = |req_stb;
        g   = -1;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && req_stb[idx]) g = idx;
        end
        full  = (ordq.size() >= DEPTH);
        empty = (ordq.size() == 0);
        issue = any && !full && mul_arg_rdy;
        check_eq("arg_stb", mul_arg_stb, any && !full);
        if (any && !full) check_eq("arg_dat", mul_arg_dat, req_dat[g*W +: W]);
        exp_rdy = '0;
        if (issue) exp_rdy[g] = 1'b1;
        check_eq("req_rdy", req_rdy, exp_rdy);
        h = empty ? 0 : ordq[0].tag;
        exp_rsp = '0;
        if (mul_res_stb && !empty) exp_rsp[h] = 1'b1;
        check_eq("rsp_stb", rsp_stb, exp_rsp);
        exp_res_rdy = !empty && rsp_rdy[h];
        check_eq("res_rdy", mul_res_rdy, exp_res_rdy);
        if (exp_rsp != 0) check_eq("rsp_dat", rsp_dat, ordq[0].p);
        check_eq("err", err, m_err);

        if (req_rdy != 0) obs_q.push_back(onehot_idx(req_rdy));
        if (mul_res_stb && empty) m_err = 1'b1;
        if (mul_res_stb && exp_res_rdy) begin
            void'(ordq.pop_front());
            res_acc = 1'b1;
        end
        if (issue) begin
            pair  = req_dat[g*W +: W];
            e.tag = g;
            e.p   = mul_ref(pair);
            ordq.push_back(e);
            m_ptr  = (g + 1) % N;
            acc[g] = 1'b1;
        end
    endtask

    initial begin
        bit seen;

        for (int i = 0; i < N; i++) inj_dat[i] = '0;
        do_reset();

        // single request, {b,a} = {3,-5}
        p_req = 0; p_arg = 100; p_res = 100; p_rsp = 100;
        inj_stb[0] = 1'b1; inj_dat[0] = 32'h0003_FFFB;
        cycle();
        check_eq("single_arg_dat", mul_arg_dat, 32'h0003_FFFB);
        check_eq("single_req_rdy", req_rdy, 4'b0001);
        cycle();
        check_eq("single_rsp_stb", rsp_stb, 4'b0001);
        check_eq("single_rsp_dat", rsp_dat, 32'hFFFF_FFF1);

        // all requesters continuously asserting: strict rotation
        do_reset();
        p_req = 100; p_arg = 100; p_res = 100; p_rsp = 100;
        obs_q.delete();
        for (int c = 0; c < 12; c++) cycle();
        check_eq("rr_ngrant", obs_q.size() >= 8, 1);
        for (int k = 0; k < 8 && k < obs_q.size(); k++) check_eq("rr_order", obs_q[k], k % N);

        // result stall: only DEPTH issues, then stall
        do_reset();
        p_req = 0; p_arg = 100; p_res = 0; p_rsp = 100;
        inj_stb = 4'b1110;
        inj_dat[1] = 32'h7FFF_7FFF; inj_dat[2] = 32'h0002_0005; inj_dat[3] = 32'hFFFF_0009;
        obs_q.delete();
        for (int c = 0; c < 5; c++) cycle();
        check_eq("stall_issues", obs_q.size(), DEPTH);
        check_eq("stall_arg_stb", mul_arg_stb, 0);
        check_eq("stall_req_rdy", req_rdy, 0);
        p_res = 100;
        cycle();
        check_eq("stall_rsp_stb", rsp_stb, 4'b0010);
        check_eq("stall_rsp_dat", rsp_dat, 32'h3FFF_0001);
        for (int c = 0; c < 8; c++) cycle();

        // head-of-line blocking: requester 2 refuses its product
        do_reset();
        p_req = 0; p_arg = 100; p_res = 100; p_rsp = 100;
        rsp_hold = 4'b0100;
        inj_stb = 4'b1100;
        inj_dat[2] = W'($urandom); inj_dat[3] = W'($urandom);
        for (int c = 0; c < 6; c++) begin
            cycle();
            check_eq("hol_blocked3", rsp_stb[3], 0);
        end
        rsp_hold = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            cycle();
            if (rsp_stb[3]) seen = 1'b1;
        end
        check_eq("hol_released3", seen, 1);

        // spurious product with nothing outstanding
        do_reset();
        p_req = 0; p_res = 0;
        spur = 1'b1;
        cycle();
        check_eq("spur_res_rdy", mul_res_rdy, 0);
        check_eq("spur_err_before", err, 0);
        spur = 1'b0;
        cycle();
        check_eq("spur_err_set", err, 1);
        for (int c = 0; c < 3; c++) begin
            cycle();
            check_eq("spur_err_sticky", err, 1);
        end

        // reset with two tags outstanding, pointer away from zero
        do_reset();
        p_req = 0; p_arg = 100; p_res = 0; p_rsp = 100;
        inj_stb = 4'b0110;
        inj_dat[1] = W'($urandom); inj_dat[2] = W'($urandom);
        for (int c = 0; c < 3; c++) cycle();
        do_reset();
        inj_stb = 4'b1010;
        inj_dat[1] = W'($urandom); inj_dat[3] = W'($urandom);
        cycle();
        check_eq("post_rst_grant", req_rdy, 4'b0010);

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                p_req = $urandom_range(100, 10);
                p_arg = $urandom_range(100, 30);
                p_res = $urandom_range(100, 20);
                p_rsp = $urandom_range(100, 20);
            end
            if (c == 1500) do_reset();
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
